// File: rtl/riscv_pkg.sv
// Shared definitions for the riscv32 front end.
// Holds the architectural constants used by the fetch stage, the
// fetch FSM state type and a helper for sequential PC arithmetic.
package riscv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  // addi x0,x0,0 - bubble presented to decode while IF/ID is empty
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  // All-zero word is architecturally illegal; fetch stops on it
  localparam logic [XLEN-1:0] ILLEGAL_ZERO      = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Next sequential PC; wraps modulo 2^XLEN
  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   advance         - step to the next sequential word
//   redirect_valid  - load redirect_pc (wins over advance)
//   redirect_pc     - word-aligned redirect target
//   hold            - freeze the PC regardless of the other controls
//   pc              - current program counter
module fetch_pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            hold,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect mux ahead of the sequential +4 path
  always_comb begin
    pc_d = pc_q;
    if (!hold) begin
      if (redirect_valid) begin
        pc_d = redirect_pc;
      end else if (advance) begin
        pc_d = pc_next(pc_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the riscv32 core.
// Drives the PC to a combinational-read instruction memory, captures the
// returned word into the IF/ID register and hands it to decode over a
// valid/ready handshake. Execute redirects override everything; an
// all-zero word is captured and then fetch halts until a redirect.
// Optional build macro: FETCH_MISALIGN_CHK_EN - a redirect to a non
// word-aligned target halts fetch and raises a sticky fetch_exc instead
// of silently dropping the low address bits.
// Ports:
//   clk, reset                  - clock, synchronous active-low reset
//   imem_addr / imem_instr      - instruction memory address / read data
//   redirect_valid, redirect_pc - taken branch/jump from execute
//   id_ready                    - decode accepts this cycle
//   id_valid, id_instr, id_pc,
//   id_pc_plus4                 - IF/ID register towards decode
//   halted                      - fetch FSM is in HALT
//   fetch_exc                   - misaligned-redirect flag
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            halted,
  output logic            fetch_exc
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redir_target;
  logic            redir_misaligned;
  logic            cap;
  logic            instr_is_zero;
  logic            advance;

  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;

  // Low target bits never reach the PC; sequential fetch stays word-aligned
  assign redir_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHK_EN
  logic fetch_exc_q, fetch_exc_d;

  assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // Sticky until reset or the next aligned redirect
  always_comb begin
    fetch_exc_d = fetch_exc_q;
    if (redirect_valid) begin
      fetch_exc_d = redir_misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_exc_q <= 1'b0;
    end else begin
      fetch_exc_q <= fetch_exc_d;
    end
  end

  assign fetch_exc = fetch_exc_q;
`else
  logic unused_redir_lo;

  assign unused_redir_lo  = ^redirect_pc[1:0];
  assign redir_misaligned = 1'b0;
  assign fetch_exc        = 1'b0;
`endif

  // Capture only in RUN, with room in IF/ID, and never in a redirect cycle
  assign cap           = !redirect_valid && (state_q == RUN) && (!id_valid_q || id_ready);
  assign instr_is_zero = (imem_instr == ILLEGAL_ZERO);
  // The illegal word is captured but the PC stays on it
  assign advance       = cap && !instr_is_zero;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .reset          (reset),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redir_target),
    .hold           (redir_misaligned),
    .pc             (pc)
  );

  assign imem_addr = pc;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: redirect outranks the halt-on-zero transition
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = redir_misaligned ? HALT : RUN;
    end else if (cap && instr_is_zero) begin
      state_d = HALT;
    end
  end

  // FSM outputs
  always_comb begin
    halted = 1'b0;
    if (state_q == HALT) begin
      halted = 1'b1;
    end
  end

  // IF/ID next values: squash > capture > drain > hold
  always_comb begin
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    if (redirect_valid) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (cap) begin
      id_valid_d    = 1'b1;
      id_instr_d    = imem_instr;
      id_pc_d       = pc;
      id_pc_plus4_d = pc_next(pc);
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
    end else begin
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

endmodule
